// File: rtl/pong_pkg.sv
// Pong game-object definitions shared by the ball, paddle and score blocks.
package pong_pkg;

    typedef enum logic [1:0] {
        SERVE = 2'd0,
        MOVE  = 2'd1,
        GOAL  = 2'd2
    } ball_state_t;

    // Largest left/top coordinate that keeps an object of 'size' fully on screen.
    function automatic int max_pos(input int extent, input int size);
        return extent - size;
    endfunction

endpackage

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the pixel-stream record passed between draw stages.
package vga_pkg;

    localparam int H_ACTIVE = 800;
    localparam int V_ACTIVE = 600;
    localparam int CNT_W    = 11;
    localparam int RGB_W    = 12;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic             hsync;
        logic             hblnk;
        logic [CNT_W-1:0] vcount;
        logic             vsync;
        logic             vblnk;
        logic [RGB_W-1:0] rgb;
    } vga_if;

endpackage

// File: rtl/ball_ctl.sv
// Ball motion controller: frame tick detect, serve/move/goal FSM, position and velocity.
module ball_ctl
    import vga_pkg::*;
    import pong_pkg::*;
#(
    parameter int BALL_SIZE    = 8,
    parameter int SPEED        = 4,
    parameter int SERVE_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_en,
    input  logic        vblnk,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        goal_left,
    output logic        goal_right,
    output ball_state_t state
);

    localparam int X_MAX = max_pos(H_ACTIVE, BALL_SIZE);
    localparam int Y_MAX = max_pos(V_ACTIVE, BALL_SIZE);
    localparam int SC_W  = $clog2(SERVE_FRAMES + 1);

    localparam logic [10:0]        X_HOME  = 11'(X_MAX / 2);
    localparam logic [10:0]        Y_HOME  = 11'(Y_MAX / 2);
    localparam logic signed [11:0] X_MAX_S = 12'(X_MAX);
    localparam logic signed [11:0] Y_MAX_S = 12'(Y_MAX);
    localparam logic signed [11:0] SPEED_S = 12'(SPEED);
    localparam logic [SC_W-1:0]    SC_LAST = SC_W'(SERVE_FRAMES - 1);

    ball_state_t        state_nx;
    logic [SC_W-1:0]    serve_cnt, serve_cnt_nx;
    logic [10:0]        x_nx, y_nx;
    logic signed [11:0] vx, vy, vx_nx, vy_nx;
    logic signed [11:0] nx, ny;
    logic               vblnk_d, tick, step;
    logic               goal_left_nx, goal_right_nx;

    assign tick = vblnk & ~vblnk_d;
    assign step = tick & move_en;
    assign nx   = $signed({1'b0, ball_x}) + vx;
    assign ny   = $signed({1'b0, ball_y}) + vy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= SERVE;
            serve_cnt  <= '0;
            ball_x     <= X_HOME;
            ball_y     <= Y_HOME;
            vx         <= SPEED_S;
            vy         <= SPEED_S;
            vblnk_d    <= 1'b0;
            goal_left  <= 1'b0;
            goal_right <= 1'b0;
        end else begin
            state      <= state_nx;
            serve_cnt  <= serve_cnt_nx;
            ball_x     <= x_nx;
            ball_y     <= y_nx;
            vx         <= vx_nx;
            vy         <= vy_nx;
            vblnk_d    <= vblnk;
            goal_left  <= goal_left_nx;
            goal_right <= goal_right_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        serve_cnt_nx  = serve_cnt;
        x_nx          = ball_x;
        y_nx          = ball_y;
        vx_nx         = vx;
        vy_nx         = vy;
        goal_left_nx  = 1'b0;
        goal_right_nx = 1'b0;
        case (state)
            SERVE: begin
                x_nx = X_HOME;
                y_nx = Y_HOME;
                if (step) begin
                    if (serve_cnt == SC_LAST) begin
                        serve_cnt_nx = '0;
                        state_nx     = MOVE;
                    end else begin
                        serve_cnt_nx = serve_cnt + 1'b1;
                    end
                end
            end
            MOVE: begin
                // A goal wins over a vertical bounce; the vertical update is dropped.
                if (step) begin
                    if (nx <= 0) begin
                        x_nx         = '0;
                        goal_left_nx = 1'b1;
                        state_nx     = GOAL;
                    end else if (nx >= X_MAX_S) begin
                        x_nx          = X_MAX_S[10:0];
                        goal_right_nx = 1'b1;
                        state_nx      = GOAL;
                    end else begin
                        x_nx = nx[10:0];
                        if (ny <= 0) begin
                            y_nx  = '0;
                            vy_nx = -vy;
                        end else if (ny >= Y_MAX_S) begin
                            y_nx  = Y_MAX_S[10:0];
                            vy_nx = -vy;
                        end else begin
                            y_nx = ny[10:0];
                        end
                    end
                end
            end
            GOAL: begin
                x_nx         = X_HOME;
                y_nx         = Y_HOME;
                vx_nx        = -vx;
                serve_cnt_nx = '0;
                state_nx     = SERVE;
            end
            default: state_nx = SERVE;
        endcase
    end

endmodule

// File: rtl/draw_ball.sv
// VGA stage after draw_bg: overlays the square ball with one cycle of latency.
module draw_ball
    import vga_pkg::*;
    import pong_pkg::*;
#(
    parameter int          BALL_SIZE    = 8,
    parameter int          SPEED        = 4,
    parameter int          SERVE_FRAMES = 60,
    parameter logic [11:0] BALL_COLOR   = 12'hF_F_F
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        move_en,
    input  vga_if       vga_in,
    output vga_if       vga_out,
    output logic [10:0] ball_x,
    output logic [10:0] ball_y,
    output logic        goal_left,
    output logic        goal_right,
    output ball_state_t ctl_state
);

    logic in_ball;

    ball_ctl #(
        .BALL_SIZE   (BALL_SIZE),
        .SPEED       (SPEED),
        .SERVE_FRAMES(SERVE_FRAMES)
    ) u_ctl (
        .clk       (clk),
        .rst       (rst),
        .move_en   (move_en),
        .vblnk     (vga_in.vblnk),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .goal_left (goal_left),
        .goal_right(goal_right),
        .state     (ctl_state)
    );

    // 12-bit compare so ball_x + BALL_SIZE cannot wrap.
    assign in_ball = !vga_in.hblnk && !vga_in.vblnk
                  && (vga_in.hcount >= ball_x)
                  && ({1'b0, vga_in.hcount} < ({1'b0, ball_x} + 12'(BALL_SIZE)))
                  && (vga_in.vcount >= ball_y)
                  && ({1'b0, vga_in.vcount} < ({1'b0, ball_y} + 12'(BALL_SIZE)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            vga_out <= '0;
        end else begin
            vga_out <= vga_in;
            if (in_ball) begin
                vga_out.rgb <= BALL_COLOR;
            end
        end
    end

endmodule

// File: tb/tb_draw_ball.sv
// Bench for draw_ball: overlay vector table, frame-level ball model, hand-written corner sequences.
module tb_draw_ball;
    import vga_pkg::*;
    import pong_pkg::*;

    localparam int BS   = 8;
    localparam int SF   = 60;
    localparam int XMAX = 800 - BS;
    localparam int YMAX = 600 - BS;
    localparam int HX   = 396;
    localparam int HY   = 296;

    logic        clk = 1'b0;
    logic        rst;
    logic        move_en;
    vga_if       vga_in;
    vga_if       vga_out;
    logic [10:0] ball_x, ball_y;
    logic        goal_left, goal_right;
    ball_state_t ctl_state;

    int total = 0;
    int bad   = 0;

    // Frame-level ball model
    int m_x, m_y, m_vx, m_vy, m_cnt;
    bit m_serving;

    typedef struct {
        logic [10:0] h;
        logic [10:0] v;
        logic        hb;
        logic        vb;
        logic [11:0] rgb;
        logic [11:0] exp_rgb;
    } vec_t;
    vec_t vt[9];

    draw_ball dut (
        .clk       (clk),
        .rst       (rst),
        .move_en   (move_en),
        .vga_in    (vga_in),
        .vga_out   (vga_out),
        .ball_x    (ball_x),
        .ball_y    (ball_y),
        .goal_left (goal_left),
        .goal_right(goal_right),
        .ctl_state (ctl_state)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected $finish total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = HX; m_y = HY; m_vx = 4; m_vy = 4; m_cnt = 0; m_serving = 1;
    endtask

    function automatic vga_if exp_pix(input vga_if in);
        vga_if e;
        int h, v;
        e = in;
        h = int'(in.hcount);
        v = int'(in.vcount);
        if (!in.hblnk && !in.vblnk && h >= m_x && h < m_x + BS && v >= m_y && v < m_y + BS)
            e.rgb = 12'hFFF;
        return e;
    endfunction

    // One frame of game rules; g = 0 none, 1 left goal, 2 right goal.
    task automatic model_tick(input bit en, output int g);
        int nx, ny;
        g = 0;
        if (!en) return;
        if (m_serving) begin
            m_cnt++;
            if (m_cnt == SF) begin
                m_serving = 0;
                m_cnt = 0;
            end
        end else begin
            nx = m_x + m_vx;
            ny = m_y + m_vy;
            if (nx <= 0) begin
                m_x = 0; g = 1;
            end else if (nx >= XMAX) begin
                m_x = XMAX; g = 2;
            end else begin
                m_x = nx;
                if (ny <= 0) begin
                    m_y = 0; m_vy = -m_vy;
                end else if (ny >= YMAX) begin
                    m_y = YMAX; m_vy = -m_vy;
                end else begin
                    m_y = ny;
                end
            end
        end
    endtask

    // driver: one clock with a random pixel near the ball, output checked against the model
    task automatic step_pix(input logic vb, input string name);
        vga_if e;
        int h, v;
        h = m_x + int'($urandom_range(0, 11)) - 2;
        v = m_y + int'($urandom_range(0, 11)) - 2;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
        vga_in.hcount = 11'(h);
        vga_in.vcount = 11'(v);
        vga_in.hsync  = 1'($urandom_range(0, 1));
        vga_in.vsync  = 1'($urandom_range(0, 1));
        vga_in.hblnk  = ($urandom_range(0, 7) == 0);
        vga_in.vblnk  = vb;
        vga_in.rgb    = 12'($urandom);
        e = exp_pix(vga_in);
        @(posedge clk); #1;
        check(name, vga_out, e);
    endtask

    task automatic do_frame(input bit en, input int lo, input int hi);
        int g;
        ball_state_t es;
        move_en = en;
        repeat (lo) step_pix(1'b0, "pix_active");
        step_pix(1'b1, "pix_tick");
        model_tick(en, g);
        es = (g != 0) ? GOAL : (m_serving ? SERVE : MOVE);
        check("tick_x", ball_x, m_x);
        check("tick_y", ball_y, m_y);
        check("tick_goal_left", goal_left, g == 1);
        check("tick_goal_right", goal_right, g == 2);
        check("tick_state", ctl_state, es);
        if (g != 0) begin
            step_pix(1'b1, "pix_goal");
            m_x = HX; m_y = HY; m_vx = -m_vx; m_serving = 1; m_cnt = 0;
            check("goal_pulse_width", {goal_left, goal_right}, 2'b00);
            check("goal_home_x", ball_x, HX);
            check("goal_home_y", ball_y, HY);
            check("goal_state", ctl_state, SERVE);
            hi--;
        end
        repeat (hi) step_pix(1'b1, "pix_blank");
    endtask

    initial begin
        int sx, sy, n;
        vga_if e;

        // reset with random inputs
        rst = 1'b0;
        vga_in = '0;
        model_reset();
        repeat (5) begin
            move_en = 1'($urandom_range(0, 1));
            vga_in.hcount = 11'($urandom); vga_in.vcount = 11'($urandom);
            vga_in.hblnk = 1'($urandom); vga_in.vblnk = 1'($urandom);
            vga_in.hsync = 1'($urandom); vga_in.vsync = 1'($urandom);
            vga_in.rgb = 12'($urandom);
            @(posedge clk); #1;
        end
        check("rst_vga_out", vga_out, '0);
        check("rst_ball_x", ball_x, HX);
        check("rst_ball_y", ball_y, HY);
        check("rst_goals", {goal_left, goal_right}, 2'b00);
        check("rst_state", ctl_state, SERVE);

        // overlay vector table, ball at 396/296, motion frozen
        vt[0] = '{h: 396, v: 296, hb: 0, vb: 0, rgb: 12'h00F, exp_rgb: 12'hFFF};
        vt[1] = '{h: 404, v: 296, hb: 0, vb: 0, rgb: 12'h00F, exp_rgb: 12'h00F};
        vt[2] = '{h: 396, v: 296, hb: 1, vb: 0, rgb: 12'h00F, exp_rgb: 12'h00F};
        vt[3] = '{h: 403, v: 303, hb: 0, vb: 0, rgb: 12'h123, exp_rgb: 12'hFFF};
        vt[4] = '{h: 395, v: 300, hb: 0, vb: 0, rgb: 12'h456, exp_rgb: 12'h456};
        vt[5] = '{h: 400, v: 304, hb: 0, vb: 0, rgb: 12'h789, exp_rgb: 12'h789};
        vt[6] = '{h: 400, v: 295, hb: 0, vb: 0, rgb: 12'hABC, exp_rgb: 12'hABC};
        vt[7] = '{h: 400, v: 300, hb: 0, vb: 1, rgb: 12'hDEF, exp_rgb: 12'hDEF};
        vt[8] = '{h: 399, v: 299, hb: 0, vb: 0, rgb: 12'h000, exp_rgb: 12'hFFF};
        rst = 1'b1;
        move_en = 1'b0;
        for (int i = 0; i < 9; i++) begin
            vga_in = '{hcount: vt[i].h, hsync: 1'(i), hblnk: vt[i].hb, vcount: vt[i].v,
                       vsync: 1'(i >> 1), vblnk: vt[i].vb, rgb: vt[i].rgb};
            e = vga_in;
            @(posedge clk); #1;
            check("overlay_rgb", vga_out.rgb, vt[i].exp_rgb);
            check("overlay_fields", {vga_out.hcount, vga_out.vcount, vga_out.hsync,
                  vga_out.vsync, vga_out.hblnk, vga_out.vblnk},
                  {e.hcount, e.vcount, e.hsync, e.vsync, e.hblnk, e.vblnk});
        end

        // serve: 60 ticks at rest, 61st moves
        for (int f = 0; f < SF; f++) do_frame(1'b1, 3, 2);
        check("serve_rest_x", ball_x, HX);
        do_frame(1'b1, 3, 2);
        check("first_move_x", ball_x, 400);
        check("first_move_y", ball_y, 300);
        do_frame(1'b1, 3, 20);
        check("long_vblnk_x", ball_x, 404);

        // random run long enough for goals on both sides and wall bounces
        for (int f = 0; f < 450; f++)
            do_frame($urandom_range(0, 9) != 0, int'($urandom_range(2, 5)), int'($urandom_range(1, 4)));

        // get into MOVE, then freeze for 10 ticks
        n = 0;
        while (m_serving && n < 80) begin
            do_frame(1'b1, 2, 1);
            n++;
        end
        check("reach_move", ctl_state, MOVE);
        sx = m_x; sy = m_y;
        for (int f = 0; f < 10; f++) do_frame(1'b0, 2, 2);
        check("freeze_x", ball_x, sx);
        check("freeze_y", ball_y, sy);

        // mid-frame reset during MOVE
        move_en = 1'b1;
        step_pix(1'b0, "pre_rst_pix");
        rst = 1'b0;
        @(posedge clk); #1;
        model_reset();
        check("midrst_vga_out", vga_out, '0);
        check("midrst_x", ball_x, HX);
        check("midrst_y", ball_y, HY);
        check("midrst_state", ctl_state, SERVE);
        check("midrst_goals", {goal_left, goal_right}, 2'b00);
        rst = 1'b1;
        step_pix(1'b0, "resume_pix");
        do_frame(1'b1, 2, 2);
        check("post_rst_serving_x", ball_x, HX);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/draw_ball.md
Name: draw_ball

Overview:
- Pipeline stage directly downstream of draw_bg in the VGA chain.
- Overlays a square Pong ball on the background stream and owns the ball's per-frame motion: wall bounce and left/right goal detection.
- After a goal, re-serves the ball from screen centre.
- Exposes ball position and goal pulses for future paddle/score logic.

Parameters:
BALL_SIZE, 8, ball edge length in pixels
SPEED, 4, per-frame step magnitude on each axis (pixels)
SERVE_FRAMES, 60, frames the ball rests at centre after reset or a goal
BALL_COLOR, 12'hF_F_F, ball RGB (4:4:4)

Ports:
clk  input  1  pixel clock
rst  input  1  synchronous, active-low reset (0 = reset)
move_en  input  1  1 = motion and serve counting enabled; 0 = freeze
vga_in  input  vga_if  hcount[10:0], vcount[10:0], hsync, vsync, hblnk, vblnk, rgb[11:0] from draw_bg
vga_out  output  vga_if  same fields, 1-cycle delayed, ball overlaid
ball_x  output  11  current ball left edge
ball_y  output  11  current ball top edge
goal_left  output  1  1-cycle pulse: ball reached left edge
goal_right  output  1  1-cycle pulse: ball reached right edge

Behaviour:
- Active area is 800x600 (H_ACTIVE, V_ACTIVE from vga_pkg). X_MAX = H_ACTIVE-BALL_SIZE = 792. Y_MAX = V_ACTIVE-BALL_SIZE = 592.
- Reset (rst==0 at clk edge):
  - all vga_out fields 0
  - ball_x=396, ball_y=296
  - vx=+SPEED, vy=+SPEED
  - state SERVE, serve counter 0
  - goal pulses 0
  - vblnk_d 0
- Pixel path (latency exactly 1 cycle, all fields registered):
  - hcount/vcount/syncs/blanks copied from vga_in.
  - rgb = BALL_COLOR when all of the following hold, else vga_in.rgb:
    - !hblnk && !vblnk
    - ball_x <= hcount < ball_x+BALL_SIZE
    - ball_y <= vcount < ball_y+BALL_SIZE
  - Comparison uses the position registers as they are on that cycle.
- Frame tick = vga_in.vblnk rising edge (vblnk & !vblnk_d). Position and velocity change only on the tick cycle. The tick falls in blanking, so no mid-frame tearing.
- Velocity is held as signed 12-bit. Next-position arithmetic is done signed in 12 bits: nx = ball_x + vx, ny = ball_y + vy.
- FSM states SERVE, MOVE, GOAL:
  - SERVE:
    - Ball held at 396/296.
    - On tick with move_en: counter++.
    - When counter reaches SERVE_FRAMES-1 on a tick: counter <- 0, go to MOVE. The first movement happens on the following tick.
  - MOVE (on tick with move_en):
    - nx <= 0: ball_x <- 0, goal_left=1 for that cycle, go to GOAL.
    - nx >= X_MAX: ball_x <- X_MAX, goal_right=1, go to GOAL.
    - Otherwise ball_x <- nx, and the vertical rules below apply:
      - ny <= 0: ball_y <- 0, vy <- -vy.
      - ny >= Y_MAX: ball_y <- Y_MAX, vy <- -vy.
      - otherwise ball_y <- ny.
    - A goal takes precedence over a vertical bounce in the same tick; the vertical update is discarded.
  - GOAL:
    - Lasts exactly 1 cycle (not tick-gated).
    - Sets ball to 396/296 and negates vx, so the serve goes towards the scorer's side.
    - Keeps vy unchanged, clears counter, goes to SERVE.
- move_en low:
  - ticks are ignored in SERVE and MOVE (no movement, no counting)
  - pixel path is unaffected
  - GOAL still completes.
- Goal pulses are never asserted outside the tick cycle. Both can never be asserted at once.
- Reset mid-frame or mid-serve returns everything to the reset values on the next edge. The pixel output resumes passthrough 1 cycle after rst returns high.

Decomposition:
- vga_pkg (shared) holds H_ACTIVE, V_ACTIVE and pixel-field widths.
- A state typedef (SERVE/MOVE/GOAL) and the X_MAX/Y_MAX derivation live in a pong_pkg shared with future paddle/score blocks.
- Natural sub-module: ball_ctl, containing:
  - tick detect
  - FSM
  - position/velocity registers
  - goal pulses
- draw_ball keeps the registered pixel overlay and instantiates ball_ctl.

Test Plan:
- Reset: hold rst=0 for 5 cycles with a random vga_in.
  -> vga_out all 0, ball_x=396, ball_y=296, goals 0.
- Overlay timing: after reset, drive a pixel at hcount=396, vcount=296, blanks 0, rgb=12'h00F.
  -> the next cycle shows vga_out.rgb=12'hFFF.
  -> hcount=404 (one past the ball) passes 12'h00F.
  -> the same position with hblnk=1 passes input rgb.
- Serve and move: move_en=1, generate 60 vblnk rising edges.
  -> position unchanged.
  -> 61st tick: ball_x=400, ball_y=300.
  -> a vblnk held high for many cycles counts once.
- Top bounce: force ball_y=2, vy=-4 (drive via serve/motion sequence) and tick.
  -> ball_y=0, vy=+4.
  -> next tick ball_y=4.
- Right goal: ball_x=790, vx=+4, tick.
  -> goal_right=1 for exactly 1 cycle, ball_x=792 then 396/296 one cycle later, vx=-4.
  -> 60 ticks of rest before motion resumes leftward.
- Freeze and mid-run reset: move_en=0 for 10 ticks.
  -> ball unchanged.
  -> asserting rst=0 mid-frame during MOVE returns the reset values on the next edge.
